// File: rtl/tinyriscv_pkg.sv
// Shared fetch-path types and constants.
// The fetch buffer imports these to hold its {pc, inst} entries.
package tinyriscv_pkg;

  localparam int unsigned PKG_AW = 32;
  localparam int unsigned PKG_IW = 32;

  localparam logic [PKG_IW-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_AW-1:0] pc;
    logic [PKG_IW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf.sv
// FWFT buffer between fetch responses and the IF/ID register.
// Pop strobe doubles as the IF/ID enable; flush clears on redirect.
module inst_fetch_buf
  import tinyriscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned IW    = 32,
  localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          ifu_valid_i,
  output logic          ifu_ready_o,
  input  logic [AW-1:0] ifu_pc_i,
  input  logic [IW-1:0] ifu_inst_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [AW-1:0] id_pc_o,
  output logic [IW-1:0] id_inst_o,
  output logic [PW-1:0] count_o
);

  if (AW != PKG_AW || IW != PKG_IW) begin : g_width_chk
    $error("inst_fetch_buf: AW/IW must match fetch_entry_t");
  end

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("inst_fetch_buf: DEPTH must be a power of two >= 2");
  end

  fetch_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fetch_entry_t  head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  // ready is purely registered: a full buffer refuses even on a pop cycle
  assign ifu_ready_o = !full;
  assign id_valid_o  = !empty;

  assign push = ifu_valid_i && ifu_ready_o && !flush_i;
  assign pop  = id_valid_o && id_ready_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[PW-2:0]] <= '{pc: ifu_pc_i, inst: ifu_inst_i};
    end
  end

  assign head = mem[rd_ptr[PW-2:0]];

  // mask stale storage so an empty buffer presents a clean NOP
  always_comb begin
    id_pc_o   = '0;
    id_inst_o = INST_NOP;
    if (!empty) begin
      id_pc_o   = head.pc;
      id_inst_o = head.inst;
    end
  end

  assign count_o = wr_ptr - rd_ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_o <= PW'(DEPTH))
        else $error("inst_fetch_buf: occupancy exceeds DEPTH");
    end
  end

endmodule
